// File: rtl/line_buffer_7row.sv
// line_buffer_7row: six circular line memories feeding a 7-pixel vertical column per accepted pixel.
// Optional top zero padding (taps above row 0 forced to 0, output from row 0) with `LINE_BUFFER_ZERO_PAD_EN.
module line_buffer_7row #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               done_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    output logic [7*DATA_WIDTH-1:0]            col_o,
    output logic                               done_o,
    output logic [$clog2(IMG_HEIGHT)-1:0]      row_idx_o,
    output logic [$clog2(IMG_WIDTH)-1:0]       col_idx_o,
    output logic                               frame_done_o
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {FILL, STREAM, LAST} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           col_cnt;
    logic [RW-1:0]           row_cnt;
    logic [2:0]              wr_sel;
    logic [DATA_WIDTH-1:0]   mem [6][IMG_WIDTH];
    logic [7*DATA_WIDTH-1:0] col_nx;
    logic                    row_end, frame_end, fill_end, emit;

    assign row_end   = col_cnt == CW'(IMG_WIDTH - 1);
    assign frame_end = row_end && row_cnt == RW'(IMG_HEIGHT - 1);
    assign fill_end  = row_end && row_cnt == RW'(5);

`ifdef LINE_BUFFER_ZERO_PAD_EN
    assign emit = 1'b1;
`else
    assign emit = state == STREAM;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    state_nx = done_i && fill_end ? STREAM : FILL;
            STREAM:  state_nx = done_i && frame_end ? LAST : STREAM;
            default: state_nx = FILL;
        endcase
    end

    // Tap k reads memory (wr_sel-k) mod 6; tap 6 is the slot about to be overwritten.
    always_comb begin
        col_nx = '0;
        col_nx[DATA_WIDTH-1:0] = data_i;
        for (int k = 1; k < 7; k++) begin
`ifdef LINE_BUFFER_ZERO_PAD_EN
            if (int'(row_cnt) >= k)
                col_nx[k*DATA_WIDTH +: DATA_WIDTH] = mem[3'((int'(wr_sel) + 6 - k) % 6)][col_cnt];
`else
            col_nx[k*DATA_WIDTH +: DATA_WIDTH] = mem[3'((int'(wr_sel) + 6 - k) % 6)][col_cnt];
`endif
        end
    end

    always_ff @(posedge clk)
        if (done_i)
            mem[wr_sel][col_cnt] <= data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            col_cnt      <= '0;
            row_cnt      <= '0;
            wr_sel       <= '0;
            col_o        <= '0;
            done_o       <= 1'b0;
            row_idx_o    <= '0;
            col_idx_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nx;
            done_o       <= done_i && emit;
            frame_done_o <= done_i && frame_end;
            if (done_i && emit) begin
                col_o     <= col_nx;
                row_idx_o <= row_cnt;
                col_idx_o <= col_cnt;
            end
            if (done_i) begin
                col_cnt <= row_end ? '0 : col_cnt + 1'b1;
                row_cnt <= frame_end ? '0 : row_end ? row_cnt + 1'b1 : row_cnt;
                wr_sel  <= frame_end ? '0 : row_end ? (wr_sel == 3'd5 ? 3'd0 : wr_sel + 3'd1) : wr_sel;
            end
        end
    end
endmodule
